ex_muldiv_seq: RTL

EX_MULDIV_SEQ -- requirements
Module: ex_muldiv_seq

---
 rtl/my_pkg.sv | 31 +++
 rtl/ex_muldiv_seq_if.sv | 30 +++
 rtl/muldiv_sign_fix.sv | 22 ++
 rtl/ex_muldiv_seq.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/my_pkg.sv
// Shared types for the sequential RV32M multiply/divide unit.
// No logic; opcode encoding, FSM state encoding and iteration count.
// DIV state value exists only when MULDIV_DIVIDE_EN is defined.
package my_pkg;

  localparam int MULDIV_ITER = 32;
  localparam int CNT_W       = $clog2(MULDIV_ITER);

  // op[2] marks the divide class; op[1] selects remainder within it,
  // op[0] marks the unsigned divide variants.
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
`ifdef MULDIV_DIVIDE_EN
    S_DIV  = 2'd2,
`endif
    S_DONE = 2'd3
  } muldiv_state_t;

endpackage

// File: rtl/ex_muldiv_seq_if.sv
// EX-stage <-> multiply/divide sequencer request/response bundle.
// Combinational wires only, no latency.
// Request uses valid/ready; response is a one-cycle strobe with no ready.
interface ex_muldiv_seq_if;
  import my_pkg::*;

  logic        req_valid;
  logic        req_ready;
  muldiv_op_t  req_op;
  logic [31:0] req_op1;
  logic [31:0] req_op2;
  logic        flush;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_result;
  logic        busy;

  // EX stage side
  modport master (
    output req_valid, req_op, req_op1, req_op2, flush,
    input  req_ready, stall, rsp_valid, rsp_result, busy
  );

  // Sequencer side
  modport slave (
    input  req_valid, req_op, req_op1, req_op2, flush,
    output req_ready, stall, rsp_valid, rsp_result, busy
  );

endinterface

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate on N lanes of W bits.
// Purely combinational, zero latency.
// No flow control; used both to form magnitudes and to re-apply the sign.
module muldiv_sign_fix #(
  parameter int W = 32,
  parameter int N = 1
) (
  input  logic [N-1:0][W-1:0] val_i,
  input  logic [N-1:0]        neg_i,
  output logic [N-1:0][W-1:0] val_o
);

  localparam logic [W-1:0] ONE = W'(1);

  // per lane: pass through or negate
  always_comb begin
    for (int i = 0; i < N; i++) begin
      val_o[i] = neg_i[i] ? (~val_i[i] + ONE) : val_i[i];
    end
  end

endmodule

// File: rtl/ex_muldiv_seq.sv
// Sequential RV32M multiply/divide unit (radix-2 shift-add / restoring divide).
// Latency 33 cycles accept-to-result, 1 cycle for divide special cases.
// Holds req_ready low while busy and raises stall; result has no backpressure.
// Divider compiled only with MULDIV_DIVIDE_EN; otherwise divide ops return 0.
module ex_muldiv_seq
  import my_pkg::*;
(
  input logic           CLK,
  input logic           RST,
  input logic           EN,
  ex_muldiv_seq_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULDIV_ITER - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  muldiv_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  muldiv_op_t       op_q, op_d;
  logic [31:0]      a_q, a_d;       // multiplicand / divisor magnitude
  logic [63:0]      acc_q, acc_d;   // {hi, lo}: product, or {remainder, quotient}
  logic             neg_q, neg_d;   // negate product / quotient
  logic [31:0]      res_q, res_d;
`ifdef MULDIV_DIVIDE_EN
  logic             neg_rem_q, neg_rem_d;
  logic [64:0]      div_shl;
  logic [33:0]      div_diff;
  logic [63:0]      div_next;
`endif

  logic             op1_signed, op2_signed;
  logic             s1, s2;
  logic [1:0][31:0] mag;
  logic [32:0]      mul_sum;
  logic [63:0]      mul_next;
  logic [63:0]      fix_in;
  logic             fix_neg;
  logic [0:0][63:0] fix_out;
  logic [31:0]      fix_res;

  // operand signedness per RV32M opcode
  always_comb begin
    op1_signed = 1'b0;
    op2_signed = 1'b0;
    case (bus.req_op)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
        op1_signed = 1'b1;
        op2_signed = 1'b1;
      end
      OP_MULHSU: op1_signed = 1'b1;
      default: ;
    endcase
    s1 = op1_signed & bus.req_op1[31];
    s2 = op2_signed & bus.req_op2[31];
  end

  muldiv_sign_fix #(.W(32), .N(2)) u_mag (
    .val_i ({bus.req_op2, bus.req_op1}),
    .neg_i ({s2, s1}),
    .val_o (mag)
  );

  // one shift-add step: add multiplicand when lo[0], then shift right
  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_q} : 33'd0);
    mul_next = {mul_sum, acc_q[31:1]};
  end

`ifdef MULDIV_DIVIDE_EN
  // one restoring step: shift in next dividend bit, keep difference if non-negative
  always_comb begin
    div_shl  = {acc_q, 1'b0};
    div_diff = {1'b0, div_shl[64:32]} - {2'b00, a_q};
    div_next = div_diff[33] ? div_shl[63:0] : {div_diff[31:0], div_shl[31:1], 1'b1};
  end
`endif

  // select what the final negate sees on the last iteration
  always_comb begin
    fix_in  = mul_next;
    fix_neg = neg_q;
`ifdef MULDIV_DIVIDE_EN
    if (state_q == S_DIV) begin
      fix_in  = {32'd0, op_q[1] ? div_next[63:32] : div_next[31:0]};
      fix_neg = op_q[1] ? neg_rem_q : neg_q;
    end
`endif
  end

  muldiv_sign_fix #(.W(64), .N(1)) u_fix (
    .val_i (fix_in),
    .neg_i (fix_neg),
    .val_o (fix_out)
  );

  // pick low or high word of the signed result
  always_comb begin
    fix_res = (op_q == OP_MUL) ? fix_out[0][31:0] : fix_out[0][63:32];
`ifdef MULDIV_DIVIDE_EN
    if (state_q == S_DIV) fix_res = fix_out[0][31:0];
`endif
  end

  // FSM, counter and datapath next-state; everything holds when EN is low
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    res_d   = res_q;
`ifdef MULDIV_DIVIDE_EN
    neg_rem_d = neg_rem_q;
`endif
    if (EN) begin
      if (bus.flush) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (bus.req_valid) begin
              op_d  = bus.req_op;
              cnt_d = '0;
              res_d = '0;
              neg_d = s1 ^ s2;
              if (!bus.req_op[2]) begin
                state_d = S_MUL;
                a_d     = mag[0];
                acc_d   = {32'd0, mag[1]};
              end else begin
`ifdef MULDIV_DIVIDE_EN
                state_d   = S_DIV;
                a_d       = mag[1];
                acc_d     = {32'd0, mag[0]};
                neg_rem_d = s1;
                if (bus.req_op2 == 32'd0) begin
                  state_d = S_DONE;
                  res_d   = bus.req_op[1] ? bus.req_op1 : 32'hFFFF_FFFF;
                end else if (!bus.req_op[0] && bus.req_op1 == 32'h8000_0000 &&
                             bus.req_op2 == 32'hFFFF_FFFF) begin
                  state_d = S_DONE;
                  res_d   = bus.req_op[1] ? 32'd0 : 32'h8000_0000;
                end
`else
                state_d = S_DONE;
                res_d   = '0;
`endif
              end
            end
          end
          S_MUL: begin
            acc_d = mul_next;
            if (cnt_q == CNT_LAST) begin
              state_d = S_DONE;
              cnt_d   = '0;
              res_d   = fix_res;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
`ifdef MULDIV_DIVIDE_EN
          S_DIV: begin
            acc_d = div_next;
            if (cnt_q == CNT_LAST) begin
              state_d = S_DONE;
              cnt_d   = '0;
              res_d   = fix_res;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
`endif
          S_DONE:  state_d = S_IDLE;
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  // state registers, asynchronously cleared
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MUL;
      a_q     <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      res_q   <= '0;
`ifdef MULDIV_DIVIDE_EN
      neg_rem_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
`ifdef MULDIV_DIVIDE_EN
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

  // handshake, hazard and result outputs; stall forced low while in reset
  always_comb begin
    bus.req_ready  = (state_q == S_IDLE) & ~bus.flush;
    bus.busy       = (state_q != S_IDLE);
    bus.rsp_valid  = (state_q == S_DONE) & ~bus.flush;
    bus.rsp_result = bus.rsp_valid ? res_q : 32'd0;
    bus.stall      = ~RST & ((state_q == S_MUL)
`ifdef MULDIV_DIVIDE_EN
                             | (state_q == S_DIV)
`endif
                             | ((state_q == S_IDLE) & bus.req_valid & ~bus.flush));
  end

endmodule
